// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue
// Description : In-order queue of fetch-stage branch predictions {pc, dir,
//               target} awaiting resolution in ID. Each ID resolve pops the
//               oldest entry and compares the actual outcome with the
//               prediction. It then drives the predictor update bus, a
//               one-cycle mispredict pulse and the corrected fetch PC.
//               A mispredict flushes every queued entry.
//
// Ports       : clk, resetn        clock, synchronous active-low reset
//               stall              freeze all state; registered outputs hold
//               push_valid/ready   IF prediction handshake (ready = !full)
//               push_pc, push_pta  predicted slot PC, {pred_dir, pred_tar}
//               res_valid          ID resolves the oldest entry
//               res_dir/tar/type   actual outcome and branch type
//               upd_valid/pc/info  predictor update bus {dir, tar, type}
//               mispred            one-cycle misprediction pulse
//               redirect_pc        correct fetch PC, valid with mispred
//               count              current occupancy
//               stat_br/stat_miss  saturating pop / mispredict counters
//                                  (present only with BRQ_STATS_EN)
//
// Options     : `define BRQ_STATS_EN to add the statistics counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_pc,
    input  logic [32:0]      push_pta,
    input  logic             res_valid,
    input  logic             res_dir,
    input  logic [31:0]      res_tar,
    input  logic [1:0]       res_type,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic [34:0]      upd_info,
    output logic             mispred,
    output logic [31:0]      redirect_pc,
    output logic [PTR_W:0]   count
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]      stat_br,
    output logic [31:0]      stat_miss
`endif
);

    localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [31:0]    c_SEQ_STEP   = 32'd8;  // branch + delay slot

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [31:0]      r_pc_mem  [DEPTH];
    logic [32:0]      r_pta_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             r_upd_valid;
    logic [31:0]      r_upd_pc;
    logic [34:0]      r_upd_info;
    logic             r_mispred;
    logic [31:0]      r_redirect_pc;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_pc;
    logic             w_head_dir;
    logic [31:0]      w_head_tar;
    logic             w_miss;
    logic [31:0]      w_redirect;
    logic [PTR_W:0]   w_count_nxt;

    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_empty    = (r_count == '0);

    // Readiness deliberately ignores a same-cycle pop.
    assign push_ready = !w_full;
    assign w_push     = push_valid & !w_full & !stall;
    // Pop only sees entries present at the start of the cycle.
    assign w_pop      = res_valid & !w_empty & !stall;

    assign w_head_pc  = r_pc_mem[r_rd_ptr];
    assign w_head_dir = r_pta_mem[r_rd_ptr][32];
    assign w_head_tar = r_pta_mem[r_rd_ptr][31:0];

    // A not-taken pair never mispredicts on target; only a taken/taken pair
    // needs the target check.
    assign w_miss     = (res_dir != w_head_dir) |
                        (res_dir & w_head_dir & (res_tar != w_head_tar));

    assign w_redirect = res_dir ? res_tar : (w_head_pc + c_SEQ_STEP);

    assign w_count_nxt = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

    // Entry payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= push_pc;
            r_pta_mem[r_wr_ptr] <= push_pta;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and registered result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_info    <= '0;
            r_mispred     <= 1'b0;
            r_redirect_pc <= '0;
        end else if (!stall) begin
            // Pulses last exactly one active cycle.
            r_upd_valid <= w_pop;
            r_mispred   <= w_pop & w_miss;

            if (w_pop) begin
                r_upd_pc      <= w_head_pc;
                r_upd_info    <= {res_dir, res_tar, res_type};
                r_redirect_pc <= w_redirect;
            end

            if (w_pop && w_miss) begin
                // Wrong-path entries, including one pushed this cycle, are
                // discarded by rewinding both pointers.
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= w_count_nxt;
            end
        end
    end

    assign upd_valid   = r_upd_valid;
    assign upd_pc      = r_upd_pc;
    assign upd_info    = r_upd_info;
    assign mispred     = r_mispred;
    assign redirect_pc = r_redirect_pc;
    assign count       = r_count;

`ifdef BRQ_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_miss;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stat_br   <= '0;
            r_stat_miss <= '0;
        end else if (!stall) begin
            if (w_pop && (r_stat_br != '1))
                r_stat_br <= r_stat_br + 32'd1;
            if (w_pop && w_miss && (r_stat_miss != '1))
                r_stat_miss <= r_stat_miss + 32'd1;
        end
    end

    assign stat_br   = r_stat_br;
    assign stat_miss = r_stat_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_queue
// Description : Directed self-checking bench for branch_resolve_queue.
//               Inputs change 1 ns after the rising edge and outputs are
//               sampled at the same point, after the edge has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

    logic        clk;
    logic        resetn;
    logic        stall;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [32:0] push_pta;
    logic        res_valid;
    logic        res_dir;
    logic [31:0] res_tar;
    logic [1:0]  res_type;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [34:0] upd_info;
    logic        mispred;
    logic [31:0] redirect_pc;
    logic [2:0]  count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_miss;
`endif

    int n_vec;
    int n_err;

    branch_resolve_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stall       (stall),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_pc     (push_pc),
        .push_pta    (push_pta),
        .res_valid   (res_valid),
        .res_dir     (res_dir),
        .res_tar     (res_tar),
        .res_type    (res_type),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_info    (upd_info),
        .mispred     (mispred),
        .redirect_pc (redirect_pc),
        .count       (count)
`ifdef BRQ_STATS_EN
        ,
        .stat_br     (stat_br),
        .stat_miss   (stat_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        push_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic dir, input logic [31:0] tar);
        push_valid = 1'b1;
        push_pc    = pc;
        push_pta   = {dir, tar};
    endtask

    task automatic resolve(input logic dir, input logic [31:0] tar, input logic [1:0] typ);
        res_valid = 1'b1;
        res_dir   = dir;
        res_tar   = tar;
        res_type  = typ;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        stall      = 1'b0;
        push_valid = 1'b0;
        push_pc    = '0;
        push_pta   = '0;
        res_valid  = 1'b0;
        res_dir    = 1'b0;
        res_tar    = '0;
        res_type   = '0;
        step();
        step();
        resetn = 1'b1;

        // Reset state
        chk("rst_count",    count,       0);
        chk("rst_ready",    push_ready,  1);
        chk("rst_upd_v",    upd_valid,   0);
        chk("rst_mispred",  mispred,     0);
        chk("rst_upd_pc",   upd_pc,      0);
        chk("rst_upd_info", upd_info,    0);
        chk("rst_redirect", redirect_pc, 0);
`ifdef BRQ_STATS_EN
        chk("rst_stat_br",   stat_br,   0);
        chk("rst_stat_miss", stat_miss, 0);
`endif

        // Fill: four pushes, then a dropped fifth
        push(32'h100, 1'b1, 32'h500); step(); chk("fill_cnt1", count, 1);
        push(32'h104, 1'b1, 32'h500); step(); chk("fill_cnt2", count, 2);
        push(32'h108, 1'b1, 32'h500); step(); chk("fill_cnt3", count, 3);
        push(32'h10c, 1'b1, 32'h500); step(); chk("fill_cnt4", count, 4);
        chk("full_ready", push_ready, 0);
        push(32'h110, 1'b1, 32'h500); step();
        chk("drop_cnt", count, 4);

        // Full queue, push + pop together: push rejected
        push(32'h114, 1'b1, 32'h500);
        resolve(1'b1, 32'h500, 2'b10);
        step();
        chk("fpp_cnt",   count,     3);
        chk("fpp_upd_v", upd_valid, 1);
        chk("fpp_upd_pc", upd_pc,   32'h100);
        chk("fpp_info",  upd_info,  {1'b1, 32'h500, 2'b10});
        chk("fpp_miss",  mispred,   0);
        idle(); step();
        chk("pulse_drop", upd_valid, 0);
        chk("ready_back", push_ready, 1);

        // Drain in order; dropped pushes must not appear
        resolve(1'b1, 32'h500, 2'b01); step(); chk("drain1_pc", upd_pc, 32'h104);
        step(); chk("drain2_pc", upd_pc, 32'h108);
        step(); chk("drain3_pc", upd_pc, 32'h10c);
        chk("drain_cnt", count, 0);
        chk("drain_upd_v", upd_valid, 1);
        // Resolve while empty: ignored, pulse drops, fields hold
        step();
        chk("emp_upd_v", upd_valid, 0);
        chk("emp_cnt",   count,     0);
        chk("emp_pc",    upd_pc,    32'h10c);

        // Empty queue, push + pop together: pop ignored
        push(32'h1000, 1'b1, 32'h2000);
        resolve(1'b0, 32'h0, 2'b00);
        step();
        chk("epp_cnt",   count,     1);
        chk("epp_upd_v", upd_valid, 0);

        // Correct taken prediction
        idle();
        resolve(1'b1, 32'h2000, 2'b10);
        step();
        chk("hit_upd_v", upd_valid, 1);
        chk("hit_info",  upd_info,  {1'b1, 32'h2000, 2'b10});
        chk("hit_pc",    upd_pc,    32'h1000);
        chk("hit_miss",  mispred,   0);
        chk("hit_cnt",   count,     0);

        // Direction miss with 3 queued plus same-cycle push: full flush
        idle();
        push(32'h1000, 1'b0, 32'h0);    step();
        push(32'h1010, 1'b1, 32'h4000); step();
        push(32'h1020, 1'b0, 32'h0);    step();
        chk("q3_cnt", count, 3);
        push(32'h1030, 1'b1, 32'h4000);
        resolve(1'b1, 32'h3000, 2'b01);
        step();
        chk("flush_miss",  mispred,     1);
        chk("flush_redir", redirect_pc, 32'h3000);
        chk("flush_cnt",   count,       0);
        chk("flush_pc",    upd_pc,      32'h1000);
        idle(); step();
        chk("flush_mdrop", mispred, 0);
        chk("flush_cnt2",  count,   0);

        // Predicted taken, actually not taken: redirect to pc+8
        push(32'h1000, 1'b1, 32'h2000); step(); idle();
        resolve(1'b0, 32'h0, 2'b01); step();
        chk("nt_miss",  mispred,     1);
        chk("nt_redir", redirect_pc, 32'h1008);
        chk("nt_info",  upd_info,    {1'b0, 32'h0, 2'b01});

        // Both taken, target differs
        idle();
        push(32'h2000, 1'b1, 32'h2100); step(); idle();
        resolve(1'b1, 32'h2200, 2'b11); step();
        chk("tar_miss",  mispred,     1);
        chk("tar_redir", redirect_pc, 32'h2200);

        // Both not taken, targets differ: not a miss
        idle();
        push(32'h3000, 1'b0, 32'h1234); step(); idle();
        resolve(1'b0, 32'h9999, 2'b00); step();
        chk("ntnt_miss", mispred,   0);
        chk("ntnt_upd",  upd_valid, 1);

        // pc+8 wraps around 2^32
        idle();
        push(32'hFFFF_FFFC, 1'b1, 32'h10); step(); idle();
        resolve(1'b0, 32'h0, 2'b01); step();
        chk("wrap_miss",  mispred,     1);
        chk("wrap_redir", redirect_pc, 32'h0000_0004);

        // Stall holds everything, including an active pulse
        idle();
        push(32'h5000, 1'b1, 32'h6000); step();
        push(32'h5010, 1'b1, 32'h6000); step();
        idle();
        resolve(1'b1, 32'h6000, 2'b11); step();
        chk("pre_stall_v",   upd_valid, 1);
        chk("pre_stall_cnt", count,     1);
        stall = 1'b1;
        push(32'h5100, 1'b1, 32'h0);
        resolve(1'b0, 32'h0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_cnt",  count,     1);
            chk("stall_v",    upd_valid, 1);
            chk("stall_pc",   upd_pc,    32'h5000);
            chk("stall_miss", mispred,   0);
        end
        // Reset wins over stall
        resetn = 1'b0;
        step();
        chk("rs_cnt",  count,     0);
        chk("rs_miss", mispred,   0);
        chk("rs_v",    upd_valid, 0);
        chk("rs_pc",   upd_pc,    0);
        resetn = 1'b1;
        stall  = 1'b0;
        idle();
        step();
        chk("post_rs_cnt", count, 0);

`ifdef BRQ_STATS_EN
        // Ten pops, misses on i = 0, 4, 8
        for (int i = 0; i < 10; i++) begin
            idle();
            push(32'h8000 + 32'(i) * 32'h10, 1'b1, 32'h7000); step();
            idle();
            resolve(1'b1, (i % 4 == 0) ? 32'h7004 : 32'h7000, 2'b10); step();
        end
        idle(); step();
        chk("stat_br",   stat_br,   10);
        chk("stat_miss", stat_miss, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
